// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader : framed byte-stream boot loader for the stack CPU program RAM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module program_loader #(
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   words_loaded
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CNT_HI  = 4'd1;
  localparam logic [3:0] S_CNT_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHECK   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERROR   = 4'd8;

  localparam logic [16:0] C_MAX_WORDS = 17'd1 << AWIDTH;

  logic [3:0]        state_q, state_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_data_q, mem_data_d;
  logic [AWIDTH:0]   words_q, words_d;
  logic [AWIDTH:0]   remaining_q, remaining_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic        w_xfer;
  logic        w_start;
  logic [15:0] w_count;

  assign w_xfer  = in_valid & in_ready;
  assign w_start = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERROR));
  assign w_count = {cnt_hi_q, in_data};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      words_q     <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      cnt_hi_q    <= '0;
      cpu_hold_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      words_q     <= words_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      cnt_hi_q    <= cnt_hi_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_CNT_HI;
      S_CNT_HI:  if (w_xfer) state_d = S_CNT_LO;
      S_CNT_LO: begin
        if (w_xfer) begin
          if ({1'b0, w_count} > C_MAX_WORDS) state_d = S_ERROR;
          else if (w_count == 16'd0)         state_d = S_CHECK;
          else                               state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_xfer) state_d = S_DATA_LO;
      S_DATA_LO: if (w_xfer) state_d = S_WRITE;
      S_WRITE:   state_d = (remaining_q == (AWIDTH+1)'(1)) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (w_xfer) state_d = (in_data == acc_q) ? S_DONE : S_ERROR;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    words_d     = words_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    cnt_hi_d    = cnt_hi_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;

    if (w_start) begin
      mem_addr_d = '0;
      words_d    = '0;
      acc_d      = '0;
      cpu_hold_d = 1'b1;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end

    // The checksum byte itself is compared, never accumulated.
    if (w_xfer && (state_q != S_CHECK)) acc_d = acc_q ^ in_data;

    case (state_q)
      S_CNT_HI: if (w_xfer) cnt_hi_d = in_data;
      S_CNT_LO: begin
        if (w_xfer) begin
          remaining_d = w_count[AWIDTH:0];
          if ({1'b0, w_count} > C_MAX_WORDS) begin
            busy_d  = 1'b0;
            error_d = 1'b1;
          end
        end
      end
      S_DATA_HI: if (w_xfer) mem_data_d[15:8] = in_data;
      S_DATA_LO: if (w_xfer) mem_data_d[7:0]  = in_data;
      S_WRITE: begin
        mem_addr_d  = mem_addr_q + AWIDTH'(1);
        words_d     = words_q + (AWIDTH+1)'(1);
        remaining_d = remaining_q - (AWIDTH+1)'(1);
      end
      S_CHECK: begin
        if (w_xfer) begin
          busy_d = 1'b0;
          if (in_data == acc_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_CNT_HI) | (state_q == S_CNT_LO) | (state_q == S_DATA_HI) |
               (state_q == S_DATA_LO) | (state_q == S_CHECK);
    mem_wr   = (state_q == S_WRITE);
  end

  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign words_loaded = words_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader : directed self-checking bench for program_loader
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;

  localparam int AWIDTH = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_wr;
  logic [AWIDTH-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [AWIDTH:0]   words_loaded;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol = 0;

  logic [AWIDTH-1:0] wr_addr[$];
  logic [15:0]       wr_data[$];
  logic [7:0]        xfer_log[$];

  program_loader #(.AWIDTH(AWIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      if (in_ready) viol++;
    end
    if (in_valid && in_ready) xfer_log.push_back(in_data);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = ~b;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL handshake_timeout byte %h never accepted (in_ready=%b)", b, in_ready);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps ? int'($urandom_range(0, 3)) : 0);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, mem_wr, cpu_hold, busy, done, error} !== 6'b001000)
      $display("FAIL reset_flags got %b want 001000", {in_ready, mem_wr, cpu_hold, busy, done, error});
    else pass_cnt++;
    total_cnt++;
    if ({mem_addr, mem_data, words_loaded} !== '0)
      $display("FAIL reset_data addr=%h data=%h words=%0d want all 0", mem_addr, mem_data, words_loaded);
    else pass_cnt++;
  endtask

  task automatic test_good_load(input bit gaps, input string tag);
    int wb, xb;
    logic [7:0] fr[$];
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    wb = wr_addr.size();
    xb = xfer_log.size();
    pulse_start();
    total_cnt++;
    if ({busy, cpu_hold, done, error} !== 4'b1100)
      $display("FAIL %s_started busy/hold/done/err=%b want 1100", tag, {busy, cpu_hold, done, error});
    else pass_cnt++;
    send_frame(fr, gaps);
    total_cnt++;
    if (wr_addr.size() - wb != 2 || wr_addr[wb] !== 10'd0 || wr_data[wb] !== 16'h1234 ||
        wr_addr[wb+1] !== 10'd1 || wr_data[wb+1] !== 16'hABCD)
      $display("FAIL %s_writes n=%0d w0=%h:%h w1=%h:%h want 2 writes 000:1234 001:abcd", tag,
               wr_addr.size() - wb, wr_addr[wb], wr_data[wb], wr_addr[wb+1], wr_data[wb+1]);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, error, cpu_hold} !== 4'b0100 || words_loaded !== 11'd2 || mem_addr !== 10'd2)
      $display("FAIL %s_status b/d/e/h=%b words=%0d addr=%0d want 0100 2 2", tag,
               {busy, done, error, cpu_hold}, words_loaded, mem_addr);
    else pass_cnt++;
    total_cnt++;
    if (xfer_log.size() - xb != 7)
      $display("FAIL %s_xfer_count got %0d want 7", tag, xfer_log.size() - xb);
    else begin
      bit ok = 1'b1;
      foreach (fr[i]) if (xfer_log[xb+i] !== fr[i]) ok = 1'b0;
      if (!ok) $display("FAIL %s_xfer_bytes stream differs from sent frame", tag);
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_checksum();
    int wb;
    wb = wr_addr.size();
    pulse_start();
    total_cnt++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_from_done hold=%b done=%b busy=%b want 1 0 1", cpu_hold, done, busy);
    else pass_cnt++;
    send_frame('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43}, 1'b0);
    total_cnt++;
    if (wr_addr.size() - wb != 2 || wr_data[wb] !== 16'h1234 || wr_data[wb+1] !== 16'hABCD)
      $display("FAIL badsum_writes n=%0d d0=%h d1=%h want 2 1234 abcd", wr_addr.size() - wb,
               wr_data[wb], wr_data[wb+1]);
    else pass_cnt++;
    total_cnt++;
    if ({busy, done, error, cpu_hold} !== 4'b0011)
      $display("FAIL badsum_status b/d/e/h=%b want 0011", {busy, done, error, cpu_hold});
    else pass_cnt++;
  endtask

  task automatic test_empty_oversize();
    int wb, xb;
    wb = wr_addr.size();
    pulse_start();
    send_frame('{8'h00, 8'h00, 8'h00}, 1'b0);
    total_cnt++;
    if (wr_addr.size() != wb || done !== 1'b1 || error !== 1'b0 || words_loaded !== 11'd0)
      $display("FAIL empty_image writes=%0d done=%b err=%b words=%0d want 0 1 0 0",
               wr_addr.size() - wb, done, error, words_loaded);
    else pass_cnt++;
    pulse_start();
    send_frame('{8'h04, 8'h01}, 1'b0);
    total_cnt++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL oversize_status err=%b done=%b busy=%b rdy=%b want 1 0 0 0",
               error, done, busy, in_ready);
    else pass_cnt++;
    xb = xfer_log.size();
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    total_cnt++;
    if (xfer_log.size() != xb || wr_addr.size() != wb || error !== 1'b1)
      $display("FAIL oversize_no_consume xfers=%0d writes=%0d err=%b want 0 0 1",
               xfer_log.size() - xb, wr_addr.size() - wb, error);
    else pass_cnt++;
  endtask

  task automatic test_full_image();
    int wb, bad;
    logic [7:0]  fr[$];
    logic [15:0] w;
    wb = wr_addr.size();
    fr.push_back(8'h04);
    fr.push_back(8'h00);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i) ^ 16'h5A5A;
      fr.push_back(w[15:8]);
      fr.push_back(w[7:0]);
    end
    // Each data byte column appears an even number of times, so only 04^00 survives.
    fr.push_back(8'h04);
    pulse_start();
    send_frame(fr, 1'b0);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wr_addr[wb+i] !== 10'(i) || wr_data[wb+i] !== (16'(i) ^ 16'h5A5A)) bad++;
    total_cnt++;
    if (wr_addr.size() - wb != 1024 || bad != 0)
      $display("FAIL full_writes n=%0d bad=%0d want 1024 0", wr_addr.size() - wb, bad);
    else pass_cnt++;
    total_cnt++;
    if (words_loaded !== 11'd1024 || done !== 1'b1 || error !== 1'b0 || mem_addr !== 10'd0)
      $display("FAIL full_status words=%0d done=%b err=%b addr=%0d want 1024 1 0 0",
               words_loaded, done, error, mem_addr);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int wb;
    logic [7:0] fr[$];
    wb = wr_addr.size();
    fr = '{8'h00, 8'h08};
    for (int i = 0; i < 5; i++) begin
      fr.push_back(8'h10 + 8'(i));
      fr.push_back(8'hA0 + 8'(i));
    end
    fr.push_back(8'h77);
    pulse_start();
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], 0);
      if (i == 4) begin
        in_valid = 1'b0;
        pulse_start();
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (words_loaded !== 11'd5 || wr_addr.size() - wb != 5 || busy !== 1'b1 || in_ready !== 1'b1 ||
        wr_data[wb+4] !== 16'h14A4)
      $display("FAIL midload_start_ignored words=%0d writes=%0d busy=%b rdy=%b w4=%h want 5 5 1 1 14a4",
               words_loaded, wr_addr.size() - wb, busy, in_ready, wr_data[wb+4]);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++;
    if ({in_ready, mem_wr, cpu_hold, busy, done, error} !== 6'b001000 ||
        {mem_addr, mem_data, words_loaded} !== '0)
      $display("FAIL async_reset flags=%b addr=%h data=%h words=%0d want 001000 0 0 0",
               {in_ready, mem_wr, cpu_hold, busy, done, error}, mem_addr, mem_data, words_loaded);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_good_load(1'b0, "good");
    test_bad_checksum();
    test_empty_oversize();
    test_good_load(1'b1, "stall");
    total_cnt++;
    if (viol != 0) $display("FAIL ready_in_write got %0d WRITE cycles with in_ready=1 want 0", viol);
    else pass_cnt++;
    test_full_image();
    test_async_reset();
    test_good_load(1'b0, "after_reset");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
Name: program_loader

Overview:
- Byte-stream boot loader sitting directly upstream of the stack CPU's 16-bit-word, 10-bit-address program memory.
- Receives a framed image over a valid/ready byte interface, assembles big-endian 16-bit instructions and writes them to consecutive program-memory addresses from 0.
- Holds the CPU in reset until a load completes with a good checksum.

Parameters:
- AWIDTH, 10, program memory address width; max image = 2^AWIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load; ignored while busy=1.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at rising edge.
- mem_wr  output  1  program memory write strobe, one cycle per word.
- mem_addr  output  AWIDTH  write address.
- mem_data  output  16  write data.
- cpu_hold  output  1  1 = keep CPU in reset.
- busy  output  1  load in progress.
- done  output  1  last load succeeded (sticky).
- error  output  1  last load failed (sticky).
- words_loaded  output  AWIDTH+1  words written in current/last load.

Behaviour:
- Frame format: CNT_HI, CNT_LO (16-bit word count N, big-endian), then N × (HI byte, LO byte), then one checksum byte equal to the XOR of all preceding frame bytes, count bytes included.
- Reset (rst=0, async) values:
  - state IDLE; in_ready=0, mem_wr=0.
  - mem_addr=0, mem_data=0, words_loaded=0, checksum accumulator=0.
  - cpu_hold=1, busy=0, done=0, error=0.
  - Reset mid-load aborts immediately; partial memory contents are left as written.
- States:
  - IDLE: in_ready=0. On start: clear done, error, words_loaded, mem_addr and accumulator; set cpu_hold=1 and busy=1; go to CNT_HI.
  - CNT_HI / CNT_LO: in_ready=1; each accepted byte is XORed into the accumulator.
    - After CNT_LO, N>2^AWIDTH → ERROR.
    - After CNT_LO, N=0 → CHECK.
    - Otherwise → DATA_HI.
  - DATA_HI: in_ready=1; accepted byte latched to mem_data[15:8] and accumulated; → DATA_LO.
  - DATA_LO: in_ready=1; accepted byte latched to mem_data[7:0] and accumulated; → WRITE.
  - WRITE: one cycle, in_ready=0, mem_wr=1 with mem_addr/mem_data stable. Next edge: mem_addr+1, words_loaded+1, remaining-1; remaining becomes 0 → CHECK, else → DATA_HI.
  - CHECK: in_ready=1; accepted byte compared to accumulator. Equal → DONE, else → ERROR.
  - DONE: busy=0, done=1, cpu_hold=0, in_ready=0; stays until start.
  - ERROR: busy=0, error=1, cpu_hold=1, in_ready=0; stays until start.
- Handshake rules:
  - in_ready is driven from state only and never depends on in_valid combinationally.
  - in_valid=0 in any receive state stalls without timeout.
  - Bytes offered while in_ready=0 are not consumed.
- Address wrap: N=2^AWIDTH writes 0..2^AWIDTH-1. mem_addr increments after the final write and wraps to 0; the wrapped value is unused.
- Throughput: 3 cycles per word minimum (HI, LO, WRITE).
- start while busy is ignored. start in DONE/ERROR begins a new load and reasserts cpu_hold the next cycle.
- Only one state register; all outputs are registered, except in_ready and mem_wr, which are decoded from state.

Test Plan:
- Good load: start; bytes 00 02 12 34 AB CD 42 with in_valid held high → mem_wr at addr 0 data 0x1234, then addr 1 data 0xABCD; done=1, error=0, cpu_hold=0, words_loaded=2.
- Bad checksum: same frame with last byte 0x43 → both words still written; error=1, done=0, cpu_hold=1.
- Empty and oversize images:
  - 00 00 00 → no mem_wr; done=1, words_loaded=0.
  - 04 01 → error=1 right after CNT_LO; in_ready=0; later bytes not consumed.
- Stall and backpressure: random in_valid gaps on the good-load frame → identical memory writes. Check that in_ready=0 in every WRITE cycle and that no byte is lost or duplicated.
- Full image: N=0x0400, data word i = i ^ 0x5A5A, correct checksum → 1024 writes at addrs 0..1023; words_loaded=1024; done=1.
- Async reset during DATA_LO of word 5 → outputs reach reset values without a clock edge. A subsequent start plus the good-load frame succeeds. start pulses issued mid-load are ignored.
